// File: rtl/extend_unit_pkg.sv
// Shared encodings and default widths for the sign/zero extender.
// Pure declarations; no logic, no latency, no flow control.
package extend_unit_pkg;

    localparam logic EXT_ZERO = 1'b1;
    localparam logic EXT_SIGN = 1'b0;

    localparam int XLEN   = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

endpackage

// File: rtl/extend_core.sv
// Combinational extend: zero fill or MSB replication from IN_WIDTH to OUT_WIDTH.
// Zero latency; no flow control.
module extend_core
    import extend_unit_pkg::*;
#(
    parameter int IN_WIDTH  = BYTE_W,
    parameter int OUT_WIDTH = XLEN
) (
    input  logic [IN_WIDTH-1:0]  data,
    input  logic                 uext,
    output logic [OUT_WIDTH-1:0] res
);

    generate
        if (IN_WIDTH == OUT_WIDTH) begin : g_same
            // No fill field exists, so the extension mode is irrelevant.
            logic unused_uext;
            assign unused_uext = uext;
            assign res         = data;
        end else begin : g_ext
            logic fill_bit;
            assign fill_bit = (uext == EXT_SIGN) & data[IN_WIDTH-1];
            assign res      = {{(OUT_WIDTH-IN_WIDTH){fill_bit}}, data};
        end
    endgenerate

endmodule

// File: rtl/extend_unit.sv
// Registered sign/zero extender; defining EXTEND_COMB_OUT_EN adds a same-cycle res_comb port.
// One cycle latency, one operand per cycle, no backpressure or stall.
module extend_unit
    import extend_unit_pkg::*;
#(
    parameter int IN_WIDTH  = BYTE_W,
    parameter int OUT_WIDTH = XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  data,
    input  logic                 uext,
`ifdef EXTEND_COMB_OUT_EN
    output logic [OUT_WIDTH-1:0] res_comb,
`endif
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] res
);

    generate
        if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH) begin : g_bad_width
            $error("extend_unit: IN_WIDTH must be in 1..OUT_WIDTH");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] ext_res;
    logic [OUT_WIDTH-1:0] res_d;
    logic [OUT_WIDTH-1:0] res_q;
    logic                 out_valid_q;

    extend_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .data (data),
        .uext (uext),
        .res  (ext_res)
    );

    // Result holds across bubbles so consumers never see X or a cleared value.
    always_comb begin
        res_d = res_q;
        if (in_valid) begin
            res_d = ext_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            res_q       <= res_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;

`ifdef EXTEND_COMB_OUT_EN
    assign res_comb = ext_res;
`endif

endmodule

// File: tb/tb_extend_unit.sv
// Self-checking bench for extend_unit: byte (8->32) and halfword (16->32) instances.
module tb_extend_unit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        b_vld, b_uext, b_out_vld;
    logic [7:0]  b_dat;
    logic [31:0] b_res;

    logic        h_vld, h_uext, h_out_vld;
    logic [15:0] h_dat;
    logic [31:0] h_res;

`ifdef EXTEND_COMB_OUT_EN
    logic [31:0] b_res_comb;
    logic [31:0] h_res_comb;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_b[$];
    logic [31:0] q_h[$];

    always #5 clk = ~clk;

    extend_unit #(.IN_WIDTH(8), .OUT_WIDTH(32)) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_vld),
        .data      (b_dat),
        .uext      (b_uext),
`ifdef EXTEND_COMB_OUT_EN
        .res_comb  (b_res_comb),
`endif
        .out_valid (b_out_vld),
        .res       (b_res)
    );

    extend_unit #(.IN_WIDTH(16), .OUT_WIDTH(32)) u_half (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (h_vld),
        .data      (h_dat),
        .uext      (h_uext),
`ifdef EXTEND_COMB_OUT_EN
        .res_comb  (h_res_comb),
`endif
        .out_valid (h_out_vld),
        .res       (h_res)
    );

    task automatic test_reset();
        logic [31:0] exp;
        rst_n = 1'b0;
        b_vld = 1'b1; b_dat = 8'hFF; b_uext = 1'b0;
        h_vld = 1'b1; h_dat = 16'hFFFF; h_uext = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (b_out_vld !== 1'b0) begin n_err++; $display("FAIL reset_b_vld got %b want 0", b_out_vld); end
        n_cmp++; if (b_res !== 32'h0) begin n_err++; $display("FAIL reset_b_res got %h want 00000000", b_res); end
        n_cmp++; if (h_out_vld !== 1'b0) begin n_err++; $display("FAIL reset_h_vld got %b want 0", h_out_vld); end
        n_cmp++; if (h_res !== 32'h0) begin n_err++; $display("FAIL reset_h_res got %h want 00000000", h_res); end
        h_vld = 1'b0;
        rst_n = 1'b1;
        q_b.push_back(32'hFFFFFFFF);
        @(negedge clk);
        b_vld = 1'b0;
        n_cmp++; if (b_out_vld !== 1'b1) begin n_err++; $display("FAIL reset_first_vld got %b want 1", b_out_vld); end
        exp = q_b.pop_front();
        n_cmp++; if (b_res !== exp) begin n_err++; $display("FAIL reset_first_res got %h want %h", b_res, exp); end
        @(negedge clk);
        n_cmp++; if (b_out_vld !== 1'b0) begin n_err++; $display("FAIL reset_after_vld got %b want 0", b_out_vld); end
    endtask

    task automatic test_byte_extend();
        logic [7:0]  dt[4];
        logic        ut[4];
        logic [31:0] et[4];
        logic [31:0] exp;
        dt = '{8'h0F, 8'h0F, 8'h8F, 8'h8F};
        ut = '{1'b1, 1'b0, 1'b1, 1'b0};
        et = '{32'h0000000F, 32'h0000000F, 32'h0000008F, 32'hFFFFFF8F};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_vld = 1'b1; b_dat = dt[i]; b_uext = ut[i];
            q_b.push_back(et[i]);
            @(negedge clk);
            b_vld = 1'b0;
            n_cmp++; if (b_out_vld !== 1'b1) begin n_err++; $display("FAIL byte_vld[%0d] got %b want 1", i, b_out_vld); end
            exp = q_b.pop_front();
            n_cmp++; if (b_res !== exp) begin n_err++; $display("FAIL byte_res[%0d] got %h want %h", i, b_res, exp); end
        end
    endtask

    task automatic test_half_extend();
        logic [15:0] dt[4];
        logic        ut[4];
        logic [31:0] et[4];
        logic [31:0] exp;
        dt = '{16'h800F, 16'h800F, 16'h000F, 16'h000F};
        ut = '{1'b1, 1'b0, 1'b1, 1'b0};
        et = '{32'h0000800F, 32'hFFFF800F, 32'h0000000F, 32'h0000000F};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            h_vld = 1'b1; h_dat = dt[i]; h_uext = ut[i];
            q_h.push_back(et[i]);
            @(negedge clk);
            h_vld = 1'b0;
            n_cmp++; if (h_out_vld !== 1'b1) begin n_err++; $display("FAIL half_vld[%0d] got %b want 1", i, h_out_vld); end
            exp = q_h.pop_front();
            n_cmp++; if (h_res !== exp) begin n_err++; $display("FAIL half_res[%0d] got %h want %h", i, h_res, exp); end
        end
    endtask

    task automatic test_valid_gating();
        logic        vt[3];
        logic [7:0]  dt[3];
        logic        ut[3];
        logic [31:0] rt[3];
        dt = '{8'h80, 8'h55, 8'h7F};
        vt = '{1'b1, 1'b0, 1'b1};
        ut = '{1'b0, 1'b1, 1'b0};
        rt = '{32'hFFFFFF80, 32'hFFFFFF80, 32'h0000007F};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_vld = vt[i]; b_dat = dt[i]; b_uext = ut[i];
            if (vt[i]) q_b.push_back(rt[i]);
            @(posedge clk);
            #1;
            n_cmp++; if (b_out_vld !== vt[i]) begin n_err++; $display("FAIL gate_vld[%0d] got %b want %b", i, b_out_vld, vt[i]); end
            if (vt[i]) void'(q_b.pop_front());
            n_cmp++; if (b_res !== rt[i]) begin n_err++; $display("FAIL gate_res[%0d] got %h want %h", i, b_res, rt[i]); end
        end
        @(negedge clk);
        b_vld = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        b_vld = 1'b1; b_dat = 8'hC3; b_uext = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++; if (b_out_vld !== 1'b1) begin n_err++; $display("FAIL arst_pre_vld got %b want 1", b_out_vld); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (b_out_vld !== 1'b0) begin n_err++; $display("FAIL arst_vld got %b want 0", b_out_vld); end
        n_cmp++; if (b_res !== 32'h0) begin n_err++; $display("FAIL arst_res got %h want 00000000", b_res); end
        @(negedge clk);
        b_vld = 1'b0;
        rst_n = 1'b1;
        q_b.delete();
        @(negedge clk);
        n_cmp++; if (b_out_vld !== 1'b0) begin n_err++; $display("FAIL arst_release_vld got %b want 0", b_out_vld); end
    endtask

    task automatic test_back_to_back();
        logic        prev_vld;
        logic [31:0] hold;
        logic [31:0] exp;
        logic [7:0]  d;
        logic        u, v;
        prev_vld = 1'b0;
        hold     = b_res;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++; if (b_out_vld !== prev_vld) begin n_err++; $display("FAIL b2b_vld[%0d] got %b want %b", i, b_out_vld, prev_vld); end
                if (prev_vld) begin
                    if (q_b.size() == 0) begin
                        n_err++; $display("FAIL b2b_queue[%0d] empty", i);
                    end else begin
                        hold = q_b.pop_front();
                    end
                end
                n_cmp++; if (b_res !== hold) begin n_err++; $display("FAIL b2b_res[%0d] got %h want %h", i, b_res, hold); end
            end
            d = 8'($urandom);
            u = 1'($urandom);
            v = (i < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
            b_vld = v; b_dat = d; b_uext = u;
            if (v) begin
                exp = u ? {24'h0, d} : {{24{d[7]}}, d};
                q_b.push_back(exp);
            end
            prev_vld = v;
        end
        @(negedge clk);
        b_vld = 1'b0;
        n_cmp++; if (b_out_vld !== prev_vld) begin n_err++; $display("FAIL b2b_last_vld got %b want %b", b_out_vld, prev_vld); end
        if (prev_vld && q_b.size() != 0) hold = q_b.pop_front();
        n_cmp++; if (b_res !== hold) begin n_err++; $display("FAIL b2b_last_res got %h want %h", b_res, hold); end
    endtask

`ifdef EXTEND_COMB_OUT_EN
    task automatic test_comb();
        logic [31:0] held;
        @(negedge clk);
        held  = b_res;
        b_vld = 1'b0; b_dat = 8'h80; b_uext = 1'b0;
        #1;
        n_cmp++; if (b_res_comb !== 32'hFFFFFF80) begin n_err++; $display("FAIL comb_sign got %h want FFFFFF80", b_res_comb); end
        b_uext = 1'b1;
        #1;
        n_cmp++; if (b_res_comb !== 32'h00000080) begin n_err++; $display("FAIL comb_zero got %h want 00000080", b_res_comb); end
        @(negedge clk);
        n_cmp++; if (b_res !== held) begin n_err++; $display("FAIL comb_reg_hold got %h want %h", b_res, held); end
        n_cmp++; if (b_out_vld !== 1'b0) begin n_err++; $display("FAIL comb_reg_vld got %b want 0", b_out_vld); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        b_vld = 1'b0; b_dat = '0; b_uext = 1'b0;
        h_vld = 1'b0; h_dat = '0; h_uext = 1'b0;
        test_reset();
        test_byte_extend();
        test_half_extend();
        test_valid_gating();
        test_async_reset();
        test_back_to_back();
`ifdef EXTEND_COMB_OUT_EN
        test_comb();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/extend_unit.md
Name: extend_unit

Overview:
- Registered sign/zero extender for the RV32 datapath.
- Widens an IN_WIDTH operand to OUT_WIDTH bits, either by zero fill (uext=1) or by replicating the operand MSB (uext=0).
- Used for sub-word load data (byte/halfword) and immediate widening ahead of the writeback mux.
- Output is registered with a valid qualifier: one cycle latency.

Parameters:
- IN_WIDTH, 8, width of input operand; must be 1..OUT_WIDTH.
- OUT_WIDTH, 32, width of extended result.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data/uext qualify this cycle.
- data  input  IN_WIDTH  operand to extend.
- uext  input  1  1 = zero-extend, 0 = sign-extend.
- out_valid  output  1  res holds a valid result.
- res  output  OUT_WIDTH  extended result.

Behaviour:
- Extension function ext(d,u):
  - res[IN_WIDTH-1:0] = d.
  - res[OUT_WIDTH-1:IN_WIDTH] = all 0 when u=1.
  - res[OUT_WIDTH-1:IN_WIDTH] = all d[IN_WIDTH-1] when u=0.
- If IN_WIDTH == OUT_WIDTH: res = d regardless of uext (no fill field).
- Elaboration error if IN_WIDTH > OUT_WIDTH or IN_WIDTH < 1.
- Reset (rst_n low, asynchronous): out_valid=0, res=0. Both held while rst_n low.
- Each rising clk edge with rst_n high:
  - out_valid <= in_valid.
  - If in_valid=1: res <= ext(data,uext).
  - If in_valid=0: res holds its previous value (no X propagation, no clearing).
- Latency: exactly 1 cycle, from the in_valid edge to out_valid/res.
- Throughput: one operand per cycle, no backpressure, no stall input.
- Back-to-back valids each produce a result on the following cycle.
- uext is sampled together with data; changing uext while in_valid=0 has no effect.
- Reset asserted mid-stream: the pending result is discarded, out_valid=0 immediately (async).
- First result after reset release appears one cycle after the first in_valid sampled high.

Optional Feature:
- Macro EXTEND_COMB_OUT_EN.
- When defined: adds output port res_comb (OUT_WIDTH) = ext(data,uext) combinationally, independent of clk, rst_n and in_valid. Used for same-cycle immediate paths.
- When undefined: the port does not exist; only the registered res/out_valid path is present.
- Registered behaviour is identical in both builds.

Decomposition:
- Shared package:
  - Constants EXT_ZERO=1'b1 and EXT_SIGN=1'b0 for uext encoding.
  - Default width constants XLEN=32, BYTE_W=8, HALF_W=16.
- One natural sub-module: extend_core.
  - Purely combinational ext() with the same two parameters.
  - Instantiated once for the register input and shared with res_comb when EXTEND_COMB_OUT_EN is defined.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, data=8'hFF -> out_valid=0, res=32'h0. Release rst_n -> result appears one cycle after the first sampled valid.
- Positive byte (8->32): data=8'b00001111 with uext=1 -> res=32'h0000000F; with uext=0 -> res=32'h0000000F. Each one cycle after valid.
- Negative byte (8->32): data=8'b10001111, uext=1 -> res=32'h0000008F; uext=0 -> res=32'hFFFFFF8F.
- Halfword (16->32): data=16'h800F, uext=1 -> res=32'h0000800F; uext=0 -> res=32'hFFFF800F. Also data=16'h000F, either uext -> res=32'h0000000F.
- Valid gating: valid beats 8'h80/uext=0, then a bubble, then 8'h7F/uext=0. Expect out_valid pattern 1,0,1 and res 32'hFFFFFF80, held 32'hFFFFFF80, 32'h0000007F. Also assert rst_n low mid-stream -> out_valid drops without waiting for a clock edge.
- Comb path (EXTEND_COMB_OUT_EN defined): data=8'h80, uext=0 -> res_comb=32'hFFFFFF80 in the same cycle, with in_valid=0. Registered res unchanged.
